// File: rtl/lfr_motor_pwm.sv
// lfr_motor_pwm
// Multi-channel H-bridge PWM driver for the line-follower drive train.
// A shared prescaled counter generates the PWM period. Each channel takes
// duty/direction/brake targets over a valid/ready command port. At every
// period boundary it ramps toward those targets, inserting coast periods
// whenever the direction reverses.
//
// Ports:
//   clk_50        system clock
//   rst_n         asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     command accepted when cmd_valid && cmd_ready (high out of reset)
//   cmd_chan      target channel; out-of-range values are accepted and dropped
//   cmd_duty      target duty in ticks (saturates at PERIOD)
//   cmd_dir       0 = forward, 1 = reverse
//   cmd_brake     1 = active brake
//   in_a, in_b    bridge input pair per channel (registered)
//   period_start  one-cycle pulse when the counter wraps to 0 (registered)
//   busy          per channel: ramping or in dead-time
module lfr_motor_pwm #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 7,
    parameter int PERIOD       = 100,
    parameter int PRESCALE     = 1,
    parameter int RAMP_STEP    = 10,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                                              clk_50,
    input  logic                                              rst_n,
    input  logic                                              cmd_valid,
    output logic                                              cmd_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cmd_chan,
    input  logic [CNT_W-1:0]                                  cmd_duty,
    input  logic                                              cmd_dir,
    input  logic                                              cmd_brake,
    output logic [CHANNELS-1:0]                               in_a,
    output logic [CHANNELS-1:0]                               in_b,
    output logic                                              period_start,
    output logic [CHANNELS-1:0]                               busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DC_W = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(RAMP_STEP);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DC_W-1:0]  DEAD_C   = DC_W'(DEAD_PERIODS);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_RAMP,
        ST_RAMP_DOWN,
        ST_DEAD,
        ST_BRAKE
    } state_t;

    logic [PS_W-1:0]     presc;
    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic                boundary;
    logic [CNT_W-1:0]    cmd_duty_sat;

    state_t              state     [CHANNELS];
    state_t              state_nxt [CHANNELS];
    logic [CNT_W-1:0]    cur_duty  [CHANNELS];
    logic [CNT_W-1:0]    duty_nxt  [CHANNELS];
    logic [CNT_W-1:0]    tgt_duty  [CHANNELS];
    logic [DC_W-1:0]     dead_cnt  [CHANNELS];
    logic [DC_W-1:0]     dead_nxt  [CHANNELS];
    logic [CHANNELS-1:0] cur_dir;
    logic [CHANNELS-1:0] dir_nxt;
    logic [CHANNELS-1:0] tgt_dir;
    logic [CHANNELS-1:0] tgt_brake;
    logic [CHANNELS-1:0] a_nxt;
    logic [CHANNELS-1:0] b_nxt;

    assign cmd_ready    = rst_n;
    assign tick         = (presc == PS_LAST);
    assign boundary     = tick && (cnt == LAST_C);
    assign cmd_duty_sat = (cmd_duty > PERIOD_C) ? PERIOD_C : cmd_duty;

    // One ramp step from cur toward tgt, limited to RAMP_STEP.
    function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            step_toward = cur + ((diff > STEP_C) ? STEP_C : diff);
        end else begin
            diff = cur - tgt;
            step_toward = cur - ((diff > STEP_C) ? STEP_C : diff);
        end
    endfunction

    // Per-channel next state, evaluated only on the period boundary so a
    // target change never alters the duty in the middle of a period.
    // Brake is honoured from every state: stopping the motor outranks
    // finishing a ramp or a dead-time.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state[i];
            duty_nxt[i]  = cur_duty[i];
            dir_nxt[i]   = cur_dir[i];
            dead_nxt[i]  = dead_cnt[i];
            if (boundary) begin
                if (tgt_brake[i]) begin
                    state_nxt[i] = ST_BRAKE;
                    duty_nxt[i]  = '0;
                end else begin
                    case (state[i])
                        ST_BRAKE: begin
                            dir_nxt[i]   = tgt_dir[i];
                            duty_nxt[i]  = step_toward('0, tgt_duty[i]);
                            state_nxt[i] = (duty_nxt[i] == tgt_duty[i]) ? ST_RUN : ST_RAMP;
                        end
                        ST_DEAD: begin
                            if (dead_cnt[i] == '0) begin
                                dir_nxt[i]   = tgt_dir[i];
                                duty_nxt[i]  = step_toward(cur_duty[i], tgt_duty[i]);
                                state_nxt[i] = (duty_nxt[i] == tgt_duty[i]) ? ST_RUN : ST_RAMP;
                            end else begin
                                dead_nxt[i] = dead_cnt[i] - 1'b1;
                            end
                        end
                        default: begin
                            if (tgt_dir[i] != cur_dir[i]) begin
                                duty_nxt[i] = cur_duty[i] -
                                              ((cur_duty[i] > STEP_C) ? STEP_C : cur_duty[i]);
                                if (duty_nxt[i] != '0) begin
                                    state_nxt[i] = ST_RAMP_DOWN;
                                end else if (DEAD_PERIODS == 0) begin
                                    dir_nxt[i]   = tgt_dir[i];
                                    state_nxt[i] = (tgt_duty[i] == '0) ? ST_RUN : ST_RAMP;
                                end else begin
                                    state_nxt[i] = ST_DEAD;
                                    dead_nxt[i]  = DEAD_C;
                                end
                            end else begin
                                duty_nxt[i]  = step_toward(cur_duty[i], tgt_duty[i]);
                                state_nxt[i] = (duty_nxt[i] == tgt_duty[i]) ? ST_RUN : ST_RAMP;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Bridge drive derived from the current counter; registered below.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            a_nxt[i] = 1'b0;
            b_nxt[i] = 1'b0;
            busy[i]  = (state[i] == ST_RAMP) || (state[i] == ST_RAMP_DOWN) ||
                       (state[i] == ST_DEAD);
            case (state[i])
                ST_DEAD: begin
                    a_nxt[i] = 1'b0;
                    b_nxt[i] = 1'b0;
                end
                ST_BRAKE: begin
                    a_nxt[i] = 1'b1;
                    b_nxt[i] = 1'b1;
                end
                default: begin
                    a_nxt[i] = (cnt < cur_duty[i]) && !cur_dir[i];
                    b_nxt[i] = (cnt < cur_duty[i]) &&  cur_dir[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
            in_a         <= '0;
            in_b         <= '0;
            cur_dir      <= '0;
            tgt_dir      <= '0;
            tgt_brake    <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i]    <= ST_RUN;
                cur_duty[i] <= '0;
                tgt_duty[i] <= '0;
                dead_cnt[i] <= '0;
            end
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            period_start <= boundary;
            in_a         <= a_nxt;
            in_b         <= b_nxt;
            cur_dir      <= dir_nxt;
            if (tick) begin
                cnt <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i]    <= state_nxt[i];
                cur_duty[i] <= duty_nxt[i];
                dead_cnt[i] <= dead_nxt[i];
                // Out-of-range channel numbers match no entry and are dropped.
                if (cmd_valid && (32'(cmd_chan) == i)) begin
                    tgt_duty[i]  <= cmd_duty_sat;
                    tgt_dir[i]   <= cmd_dir;
                    tgt_brake[i] <= cmd_brake;
                end
            end
        end
    end

endmodule
